// File: rtl/urv_dmem.sv
// urv_dmem: urv_cpu data-memory responder with optional wait states and big-endian byte-lane stores
module urv_dmem #(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_ready_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] data_q, rd_q;
  logic [3:0] sel_q;
  logic st_q, loaded, req, resp;
  logic [31:0] mem [2**ADDR_W];
  logic unused;
  assign unused = ^{dm_addr_i[31:ADDR_W+2], dm_addr_i[1:0]};
  assign req = dm_store_i | dm_load_i;
  assign resp = state == RESP;
  assign dm_ready_o = state == IDLE;
  // rd_q lives with the RAM (no reset); loaded masks it to zero until the first load after reset
  assign dm_data_l_o = loaded ? rd_q : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    state_n = state == IDLE ? (req ? (WC != 4'd0 ? WAIT : RESP) : IDLE)
            : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
    cnt_n = state == IDLE && req ? WC : state == WAIT ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      sel_q <= '0;
      st_q <= 1'b0;
      loaded <= 1'b0;
      dm_load_done_o <= 1'b0;
      dm_store_done_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && req) begin
        addr_q <= dm_addr_i[ADDR_W+1:2];
        data_q <= dm_data_s_i;
        sel_q <= dm_data_select_i;
        st_q <= dm_store_i;
      end
      dm_store_done_o <= resp && st_q;
      dm_load_done_o <= resp && !st_q;
      loaded <= loaded | (resp && !st_q);
    end
  end
  always_ff @(posedge clk_i) begin
    if (resp && st_q) begin
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[addr_q][i*8 +: 8] <= data_q[i*8 +: 8];
    end else if (resp) begin
      rd_q <= mem[addr_q];
    end
  end
endmodule

// File: tb/tb_urv_dmem.sv
// tb_urv_dmem: scoreboard bench for urv_dmem with zero and three wait states
module tb_urv_dmem;
  typedef struct {
    int u;
    bit st;
    logic [31:0] data;
    int cyc;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0] sel [2];
  logic st [2];
  logic ld [2];
  logic [31:0] rdata [2];
  logic rdy [2];
  logic ldone [2];
  logic sdone [2];
  logic [31:0] model [2][1024];
  logic [31:0] last_ld [2];
  exp_t sb [$];
  exp_t mon_e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  urv_dmem #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(addr[0]), .dm_data_s_i(wdata[0]),
    .dm_data_select_i(sel[0]), .dm_store_i(st[0]), .dm_load_i(ld[0]),
    .dm_data_l_o(rdata[0]), .dm_ready_o(rdy[0]), .dm_load_done_o(ldone[0]),
    .dm_store_done_o(sdone[0]));
  urv_dmem #(.ADDR_W(10), .WAIT_CYCLES(3)) u1 (
    .clk_i(clk), .rst_i(rst), .dm_addr_i(addr[1]), .dm_data_s_i(wdata[1]),
    .dm_data_select_i(sel[1]), .dm_store_i(st[1]), .dm_load_i(ld[1]),
    .dm_data_l_o(rdata[1]), .dm_ready_o(rdy[1]), .dm_load_done_o(ldone[1]),
    .dm_store_done_o(sdone[1]));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", n, act, req);
    end
  endtask
  task automatic chk_idle_outputs(input string n);
    for (int u = 0; u < 2; u++) begin
      chk({n, "_ready"}, 32'(rdy[u]), 1);
      chk({n, "_load_done"}, 32'(ldone[u]), 0);
      chk({n, "_store_done"}, 32'(sdone[u]), 0);
      chk({n, "_rdata"}, rdata[u], 0);
    end
  endtask
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sdone[u] || ldone[u]) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'b0, sdone[u] | ldone[u]}, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_unit", u, mon_e.u);
          chk("store_done", 32'(sdone[u]), 32'(mon_e.st));
          chk("load_done", 32'(ldone[u]), 32'(!mon_e.st));
          chk("latency_cycle", cyc, mon_e.cyc);
          chk(mon_e.st ? "rdata_hold" : "load_data", rdata[u], mon_e.data);
        end
      end
    end
  end
  task automatic txn(input int u, input bit s_, input bit l_, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] se, input bit intrude);
    int w, busy, wi;
    bit seen;
    exp_t e;
    logic [31:0] m;
    @(negedge clk);
    rst = 0;
    chk("ready_before_req", 32'(rdy[u]), 1);
    addr[u] = a; wdata[u] = d; sel[u] = se; st[u] = s_; ld[u] = l_;
    w = u ? 3 : 0;
    wi = int'((a >> 2) & 32'h3FF);
    e.u = u; e.st = s_; e.cyc = cyc + w + 2;
    if (s_) begin
      m = {{8{se[3]}}, {8{se[2]}}, {8{se[1]}}, {8{se[0]}}};
      model[u][wi] = (model[u][wi] & ~m) | (d & m);
      e.data = last_ld[u];
    end else begin
      e.data = model[u][wi];
      last_ld[u] = model[u][wi];
    end
    sb.push_back(e);
    busy = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (sdone[u] || ldone[u]) seen = 1;
      else if (!rdy[u]) busy++;
      if (intrude && k == 1) begin st[u] = 1; wdata[u] = ~d; sel[u] = 4'hF; end
      if (intrude && k == 2) begin st[u] = s_; wdata[u] = d; sel[u] = se; end
    end
    st[u] = 0;
    ld[u] = 0;
    chk("done_within_budget", 32'(seen), 1);
    chk("busy_cycles", busy, w + 1);
  endtask
  task automatic run_random(input int u, input int n);
    int t, idx;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      t = $urandom_range(0, 2);
      idx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
      txn(u, t != 1, t != 0, a, $urandom, 4'($urandom_range(0, 15)), 0);
    end
  endtask
  task automatic preinit(input int u);
    for (int i = 0; i < 16; i++) txn(u, 1, 0, 32'(i * 4), $urandom, 4'hF, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int u = 0; u < 2; u++) begin
      addr[u] = 0; wdata[u] = 0; sel[u] = 0; st[u] = 0; ld[u] = 0; last_ld[u] = 0;
    end
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    txn(0, 1, 0, 32'h10, 32'h12345678, 4'hF, 0);
    txn(0, 0, 1, 32'h10, 32'h0, 4'h0, 0);
    txn(0, 1, 0, 32'h10, 32'hAABBCCDD, 4'h8, 0);
    txn(0, 0, 1, 32'h10, 32'h0, 4'h3, 0);
    txn(0, 1, 0, 32'h10, 32'h000000EE, 4'h1, 0);
    txn(0, 0, 1, 32'h10, 32'h0, 4'h0, 0);
    chk("be_merge_model", last_ld[0], 32'hAA3456EE);
    txn(0, 1, 0, 32'h10, 32'h55555555, 4'h0, 0);
    txn(0, 0, 1, 32'h10, 32'h0, 4'h0, 0);
    txn(0, 1, 1, 32'h20, 32'h0BADF00D, 4'hF, 0);
    txn(0, 0, 1, 32'h20, 32'h0, 4'h0, 0);
    txn(0, 1, 0, 32'h1000, 32'hCAFEBABE, 4'hF, 0);
    txn(0, 0, 1, 32'h0, 32'h0, 4'h0, 0);
    preinit(0);
    run_random(0, 150);
    preinit(1);
    txn(1, 0, 1, 32'h30, 32'h0, 4'h0, 0);
    @(negedge clk);
    addr[1] = 32'h30; wdata[1] = 32'hFFFFFFFF; sel[1] = 4'hF; st[1] = 1;
    @(negedge clk);
    rst = 1;
    st[1] = 0;
    last_ld[0] = 0;
    last_ld[1] = 0;
    #1 chk_idle_outputs("abort_reset");
    @(negedge clk);
    chk_idle_outputs("abort_held");
    txn(1, 0, 1, 32'h30, 32'h0, 4'h0, 0);
    txn(0, 0, 1, 32'h20, 32'h0, 4'h0, 0);
    txn(1, 0, 1, 32'h24, 32'h0, 4'h0, 1);
    txn(1, 0, 1, 32'h24, 32'h0, 4'h0, 0);
    txn(1, 1, 0, 32'h28, 32'h13572468, 4'h6, 1);
    txn(1, 0, 1, 32'h28, 32'h0, 4'h0, 0);
    run_random(1, 150);
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/urv_dmem.md
URV_DMEM -- requirements
Module: urv_dmem

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width; depth is 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 0, meaning extra wait states inserted before each response (0..15).
REQ-003 clk_i  input  1  the only clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 dm_addr_i  input  32  byte address; word index is dm_addr_i[ADDR_W+1:2], all other bits are ignored.
REQ-006 dm_data_s_i  input  32  store data.
REQ-007 dm_data_select_i  input  4  byte-lane enables for stores.
REQ-008 dm_store_i  input  1  store request level.
REQ-009 dm_load_i  input  1  load request level.
REQ-010 dm_data_l_o  output  32  load data.
REQ-011 dm_ready_o  output  1  high when the block is idle and able to accept a request.
REQ-012 dm_load_done_o  output  1  one-cycle load completion pulse.
REQ-013 dm_store_done_o  output  1  one-cycle store completion pulse.

Function
REQ-014 The block SHALL be the responder for the urv_cpu data-memory interface and SHALL use a three-state FSM: IDLE, WAIT, RESP.
REQ-015 In IDLE, a high dm_store_i or dm_load_i SHALL be accepted at the clock edge: address, data, select and request type are captured, and the FSM moves to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-016 WAIT SHALL count WAIT_CYCLES edges on a 4-bit down-counter, then move to RESP.
REQ-017 On the RESP edge the access SHALL be performed, the matching done output set high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle after edge WAIT_CYCLES+1, counting the acceptance edge as edge 0.
REQ-019 dm_ready_o SHALL be high only in IDLE, including the cycle in which a done pulse is high.
REQ-020 Requests arriving while in WAIT or RESP SHALL be ignored, with no queuing.
REQ-021 If both dm_store_i and dm_load_i are high on acceptance, the store SHALL win; the load is neither performed nor acknowledged.
REQ-022 The requester SHALL drop its request in the cycle done is high; a request still high in IDLE SHALL be accepted as a new transaction.
REQ-023 Byte lanes are big-endian and SHALL map as follows:
- select[3] writes byte 0 = data[31:24].
- select[2] writes byte 1 = data[23:16].
- select[1] writes byte 2 = data[15:8].
- select[0] writes byte 3 = data[7:0].
REQ-024 Any select combination SHALL be legal; select 4'h0 SHALL still complete with store_done but change no memory.
REQ-025 A load SHALL return the full 32-bit word, byte 0 in [31:24], regardless of select.
REQ-026 dm_data_l_o SHALL update only when a load completes and SHALL hold its value until the next load completes.
REQ-027 Word indices SHALL wrap modulo 2**ADDR_W; no error is signalled.
REQ-028 A store followed by a load to the same word SHALL return the stored data (read-after-write).
REQ-029 The memory array SHALL be inferable as single-port block RAM with byte-write enables and registered read.

Reset
REQ-030 While rst_i is high, the block SHALL hold:
- FSM in IDLE.
- wait counter = 0.
- dm_ready_o = 1.
- dm_load_done_o = 0, dm_store_done_o = 0.
- dm_data_l_o = 32'h0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 A reset asserted before the RESP edge SHALL abort the transaction: no memory write and no done pulse.
REQ-033 The first request SHALL be accepted on the first rising edge after rst_i deasserts.

Verification
REQ-034 WAIT_CYCLES=0: store 0x12345678, select F, to addr 0x10, then load from 0x10 -> store_done one cycle, then load_done with dm_data_l_o=0x12345678, two cycles after each request.
REQ-035 Store 0xAABBCCDD select 8 to 0x10, then load 0x10 -> 0xAA345678; store select 1 with data 0x000000EE, then load -> 0xAA3456EE.
REQ-036 WAIT_CYCLES=3: load issued -> dm_ready_o low for 4 cycles, load_done 5 cycles after request; a second request during busy -> ignored, no extra done.
REQ-037 dm_store_i and dm_load_i both high, data 0x0BADF00D to 0x20 -> only store_done pulses; a later load from 0x20 returns 0x0BADF00D.
REQ-038 ADDR_W=10: store 0xCAFEBABE to 0x1000, then load 0x0 -> 0xCAFEBABE (wrap).
REQ-039 rst_i asserted in WAIT during a store of 0xFFFFFFFF to 0x30 -> no done pulse, outputs at reset values, a load from 0x30 returns the prior contents.
